// File: rtl/iob_cache_nway_lite.sv
// N-way set-associative, write-through, no-write-allocate cache with line fill.
// Optional hit/miss counters are enabled by defining IOB_CACHE_NWAY_CNT_EN.
module iob_cache_nway_lite #(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int N_WAYS     = 2,
    parameter int LINE_OFF_W = 4,
    parameter int WORD_OFF_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [FE_ADDR_W-1:0]   addr,
    input  logic [FE_DATA_W-1:0]   wdata,
    input  logic [FE_DATA_W/8-1:0] wstrb,
    output logic [FE_DATA_W-1:0]   rdata,
    output logic                   ready,
    input  logic                   invalidate,
    output logic                   mem_valid,
    output logic [FE_ADDR_W-1:0]   mem_addr,
    output logic [FE_DATA_W-1:0]   mem_wdata,
    output logic [FE_DATA_W/8-1:0] mem_wstrb,
    input  logic [FE_DATA_W-1:0]   mem_rdata,
    input  logic                   mem_ready,
    output logic [1:0]             o_dbg_state
`ifdef IOB_CACHE_NWAY_CNT_EN
    ,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);
    localparam int FE_NBYTES = FE_DATA_W / 8;
    localparam int FE_BYTE_W = $clog2(FE_NBYTES);
    localparam int NWAY_W    = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int TAG_W     = FE_ADDR_W - LINE_OFF_W - WORD_OFF_W - FE_BYTE_W;
    localparam int N_SETS    = 2 ** LINE_OFF_W;
    localparam int N_WORDS   = 2 ** WORD_OFF_W;

    // Handshakes: master valid is held with addr/wdata/wstrb until the one-cycle
    // ready pulse; mem_valid is held with its payload until the one-cycle mem_ready.
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_FILL, S_WRITE} state_t;

    state_t r_state, w_state_nxt;

    logic [FE_DATA_W-1:0]  r_data [N_WAYS][N_SETS][N_WORDS];
    logic [TAG_W-1:0]      r_tag  [N_WAYS][N_SETS];
    logic [N_WAYS-1:0]     r_vld  [N_SETS];
    logic [NWAY_W-1:0]     r_ptr  [N_SETS];

    logic [FE_DATA_W-1:0]  r_rdata;
    logic                  r_mem_valid;
    logic [FE_ADDR_W-1:0]  r_mem_addr;
    logic [FE_DATA_W-1:0]  r_mem_wdata;
    logic [FE_NBYTES-1:0]  r_mem_wstrb;
    logic [WORD_OFF_W-1:0] r_beat;
    logic [NWAY_W-1:0]     r_victim;
    logic                  r_use_ptr;
    logic                  r_inv_pend;

    logic [TAG_W-1:0]      w_tag;
    logic [LINE_OFF_W-1:0] w_idx;
    logic [WORD_OFF_W-1:0] w_word;
    logic [WORD_OFF_W-1:0] w_beat_nxt;
    logic                  w_hit;
    logic [NWAY_W-1:0]     w_hit_way;
    logic                  w_inv_found;
    logic [NWAY_W-1:0]     w_victim;
    logic [FE_DATA_W-1:0]  w_hit_word;
    logic [FE_DATA_W-1:0]  w_merged;
    logic                  w_is_write;
    logic                  w_last_beat;
    logic                  w_inv_now;
    logic                  w_unused_lsb;

    assign w_tag        = addr[FE_ADDR_W-1 -: TAG_W];
    assign w_idx        = addr[FE_BYTE_W+WORD_OFF_W +: LINE_OFF_W];
    assign w_word       = addr[FE_BYTE_W +: WORD_OFF_W];
    assign w_unused_lsb = ^addr[FE_BYTE_W-1:0];
    assign w_is_write   = (wstrb != '0);
    assign w_last_beat  = &r_beat;
    assign w_beat_nxt   = r_beat + WORD_OFF_W'(1);
    assign w_hit_word   = r_data[w_hit_way][w_idx][w_word];

    // Clear on an idle cycle without a request, otherwise on the RESP->IDLE edge.
    assign w_inv_now = ((r_state == S_IDLE) && invalidate && !valid) ||
                       ((r_state == S_RESP) && (r_inv_pend || invalidate));

    // Tag lookup and victim choice: lowest invalid way wins over the pointer.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_victim    = r_ptr[w_idx];
        for (int w = 0; w < N_WAYS; w++) begin
            if (r_vld[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = NWAY_W'(w);
            end
        end
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!r_vld[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_victim    = NWAY_W'(w);
            end
        end
    end

    always_comb begin
        w_merged = w_hit_word;
        for (int b = 0; b < FE_NBYTES; b++) begin
            if (wstrb[b]) w_merged[b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (valid) begin
                    if (w_is_write)  w_state_nxt = S_WRITE;
                    else if (w_hit)  w_state_nxt = S_RESP;
                    else             w_state_nxt = S_FILL;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_FILL:  if (mem_ready && w_last_beat) w_state_nxt = S_RESP;
            S_WRITE: if (mem_ready) w_state_nxt = S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready       = (r_state == S_RESP);
        o_dbg_state = r_state;
        rdata       = r_rdata;
        mem_valid   = r_mem_valid;
        mem_addr    = r_mem_addr;
        mem_wdata   = r_mem_wdata;
        mem_wstrb   = r_mem_wstrb;
    end

    // Line storage carries no reset; validity lives in r_vld.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((r_state == S_IDLE) && valid && w_is_write && w_hit)
                r_data[w_hit_way][w_idx][w_word] <= w_merged;
            if ((r_state == S_FILL) && mem_ready) begin
                r_data[r_victim][w_idx][r_beat] <= mem_rdata;
                if (w_last_beat) r_tag[r_victim][w_idx] <= w_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_SETS; s++) begin
                r_vld[s] <= '0;
                r_ptr[s] <= '0;
            end
            r_rdata     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_beat      <= '0;
            r_victim    <= '0;
            r_use_ptr   <= 1'b0;
            r_inv_pend  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (valid && !w_is_write) begin
                        if (w_hit) begin
                            r_rdata <= w_hit_word;
                        end else begin
                            r_victim    <= w_victim;
                            r_use_ptr   <= !w_inv_found;
                            r_beat      <= '0;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {w_tag, w_idx, {WORD_OFF_W{1'b0}}, {FE_BYTE_W{1'b0}}};
                            r_mem_wstrb <= '0;
                        end
                    end else if (valid) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= {addr[FE_ADDR_W-1:FE_BYTE_W], {FE_BYTE_W{1'b0}}};
                        r_mem_wdata <= wdata;
                        r_mem_wstrb <= wstrb;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        if (r_beat == w_word) r_rdata <= mem_rdata;
                        if (w_last_beat) begin
                            r_mem_valid               <= 1'b0;
                            r_vld[w_idx][r_victim]    <= 1'b1;
                            if (r_use_ptr) begin
                                r_ptr[w_idx] <= (r_ptr[w_idx] == NWAY_W'(N_WAYS - 1)) ?
                                                '0 : r_ptr[w_idx] + NWAY_W'(1);
                            end
                        end else begin
                            r_beat     <= w_beat_nxt;
                            r_mem_addr <= {w_tag, w_idx, w_beat_nxt, {FE_BYTE_W{1'b0}}};
                        end
                    end
                end
                S_WRITE: if (mem_ready) r_mem_valid <= 1'b0;
                default: ;
            endcase
            if (w_inv_now) begin
                for (int s = 0; s < N_SETS; s++) r_vld[s] <= '0;
            end
            r_inv_pend <= w_inv_now ? 1'b0 : (r_inv_pend || invalidate);
        end
    end

`ifdef IOB_CACHE_NWAY_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((r_state == S_IDLE) && valid) begin
            if (w_hit && (hit_cnt != 32'hFFFF_FFFF))         hit_cnt  <= hit_cnt + 32'd1;
            else if (!w_hit && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iob_cache_nway_lite.sv
// Directed bench for iob_cache_nway_lite: fills, hits, writes, replacement,
// invalidate and reset. Counter checks appear when IOB_CACHE_NWAY_CNT_EN is defined.
module tb_iob_cache_nway_lite;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        invalidate = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  dbg_state;
`ifdef IOB_CACHE_NWAY_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  iob_cache_nway_lite dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .invalidate(invalidate),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .o_dbg_state(dbg_state)
`ifdef IOB_CACHE_NWAY_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int n_xfer = 0;
  int wait_cnt = 0;
  int mem_lat = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] exp_q[$];
  logic [3:0]  exp_strb_q[$];
  logic [31:0] mem_m [int];
  logic [31:0] e_addr;
  logic [3:0]  e_strb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (mem_m.exists(k)) return mem_m[k];
    return 32'h9C + (a >> 2);
  endfunction

  // Memory responder: latency mem_lat (0 = same cycle as mem_valid rise).
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_valid && !reset) begin
      if (wait_cnt >= mem_lat) begin
        logic [31:0] w;
        wait_cnt = 0;
        n_xfer++;
        if (exp_q.size() == 0) begin
          check_eq("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e_addr = exp_q.pop_front();
          e_strb = exp_strb_q.pop_front();
          check_eq("mem_addr", mem_addr, e_addr);
          check_eq("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_strb});
        end
        if (mem_wstrb != '0) begin
          last_wdata = mem_wdata;
          w = mem_read(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
          mem_m[int'(mem_addr >> 2)] = w;
        end else begin
          mem_rdata = mem_read(mem_addr);
        end
        mem_ready = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           output logic [31:0] rd, output int lat);
    int n;
    bit got;
    @(posedge clk); #1;
    valid = 1'b1; addr = a; wdata = wd; wstrb = ws;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (ready) got = 1;
    end
    valid = 1'b0; wstrb = '0;
    if (!got) check_eq("access_timeout", 32'(n), 32'd0);
    rd = rdata;
    lat = n - 1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input bit miss,
                            input logic [31:0] exp);
    logic [31:0] rd;
    int lat, x0;
    if (miss) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back({a[31:4], 4'(b * 4)});
        exp_strb_q.push_back(4'b0);
      end
    end
    x0 = n_xfer;
    do_access(a, 32'h0, 4'b0, rd, lat);
    check_eq({tag, "_rdata"}, rd, exp);
    check_eq({tag, "_xfers"}, 32'(n_xfer - x0), miss ? 32'd4 : 32'd0);
    if (!miss) check_eq({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic write_check(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, input logic [31:0] exp_rd);
    logic [31:0] rd;
    int lat, x0;
    exp_q.push_back({a[31:2], 2'b00});
    exp_strb_q.push_back(ws);
    x0 = n_xfer;
    do_access(a, wd, ws, rd, lat);
    check_eq({tag, "_xfers"}, 32'(n_xfer - x0), 32'd1);
    check_eq({tag, "_wdata"}, last_wdata, wd);
    check_eq({tag, "_rdata_hold"}, rd, exp_rd);
  endtask

  initial begin
    int k, x0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check_eq("rst_state", {30'b0, dbg_state}, 32'd0);

    // Line fill with zero-latency memory, then hits.
    mem_lat = 0;
    read_check("fill10", 32'h10, 1, 32'hA0);
    read_check("hit14", 32'h14, 0, 32'hA1);
    @(negedge clk);
    check_eq("ready_pulse", {31'b0, ready}, 32'd0);

    // Write hit merges bytes; rdata keeps the last read value.
    mem_lat = 2;
    write_check("wr14", 32'h14, 32'h1122_3344, 4'b0011, 32'hA1);
    read_check("hit14_merged", 32'h14, 0, 32'h0000_3344);

    // No-write-allocate.
    mem_lat = 1;
    write_check("wr200", 32'h200, 32'hDEAD_BEEF, 4'b1111, 32'h0000_3344);
    read_check("fill200", 32'h200, 1, 32'hDEAD_BEEF);
    read_check("hit204", 32'h204, 0, 32'h11D);

    // Replacement in set 2: A, B, C -> C evicts A; A evicts B; C hits.
    read_check("rep_a", 32'h1020, 1, 32'h4A4);
    read_check("rep_b", 32'h2020, 1, 32'h8A4);
    read_check("rep_c", 32'h3020, 1, 32'hCA4);
    read_check("rep_a2", 32'h1020, 1, 32'h4A4);
    read_check("rep_c2", 32'h3020, 0, 32'hCA4);
    read_check("rep_b2", 32'h2020, 1, 32'h8A4);

    // Invalidate during a fill is deferred until the fill completes.
    fork
      read_check("inv_fill", 32'h40, 1, 32'hAC);
      begin
        repeat (3) @(posedge clk);
        #1 invalidate = 1'b1;
        check_eq("inv_in_fill", {31'b0, mem_valid}, 32'd1);
        @(posedge clk); #1 invalidate = 1'b0;
      end
    join
    read_check("inv_refill40", 32'h40, 1, 32'hAC);
    read_check("inv_refill10", 32'h10, 1, 32'hA0);

    // Invalidate while idle.
    @(posedge clk); #1 invalidate = 1'b1;
    @(posedge clk); #1 invalidate = 1'b0;
    read_check("idle_inv40", 32'h40, 1, 32'hAC);

    // Invalidate together with a request: lookup sees the old state.
    fork
      read_check("inv_with_req", 32'h40, 0, 32'hAC);
      begin
        @(posedge clk); #1 invalidate = 1'b1;
        @(posedge clk); #1 invalidate = 1'b0;
      end
    join
    read_check("inv_after_req", 32'h40, 1, 32'hAC);

    // Reset in the middle of a fill.
    mem_lat = 2;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(32'h80 + 32'(b * 4));
      exp_strb_q.push_back(4'b0);
    end
    x0 = n_xfer;
    @(posedge clk); #1 valid = 1'b1; addr = 32'h80; wstrb = 4'b0;
    k = 0;
    while (n_xfer < x0 + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_fill_progress", 32'(n_xfer - x0), 32'd2);
    @(posedge clk); #1 reset = 1'b1; valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_mem_valid", {31'b0, mem_valid}, 32'd0);
    check_eq("rst_mid_ready", {31'b0, ready}, 32'd0);
`ifdef IOB_CACHE_NWAY_CNT_EN
    check_eq("rst_hit_cnt", hit_cnt, 32'd0);
    check_eq("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    exp_q.delete();
    exp_strb_q.delete();
    wait_cnt = 0;
    @(posedge clk); #1 reset = 1'b0;
`ifdef IOB_CACHE_NWAY_CNT_EN
    read_check("cnt_miss", 32'h300, 1, 32'h15C);
    read_check("cnt_hit1", 32'h300, 0, 32'h15C);
    read_check("cnt_hit2", 32'h304, 0, 32'h15D);
    write_check("cnt_wmiss", 32'h900, 32'h0102_0304, 4'b0001, 32'h15D);
    check_eq("cnt_hit", hit_cnt, 32'd2);
    check_eq("cnt_miss", miss_cnt, 32'd2);
`endif
    read_check("post_rst_80", 32'h80, 1, 32'hBC);
    read_check("post_rst_10", 32'h10, 1, 32'hA0);

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
